// File: rtl/fft_pkg.sv
// Shared definitions for the SDF FFT stage sequencer.
// Mode codes, FSM states and the per-stage pipeline offset.
package fft_pkg;

    localparam logic [1:0] MODE_IDLE = 2'd0;
    localparam logic [1:0] MODE_LOAD = 2'd1;
    localparam logic [1:0] MODE_BFLY = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    function automatic int stage_offset(input int s, input int n);
        return n - (n >> s);
    endfunction

endpackage

// File: rtl/fft_stage_sequencer_if.sv
// Handshake and per-stage control bundle between the sequencer
// and the surrounding FFT datapath.
interface fft_stage_sequencer_if #(
    parameter int LOG2N = 7,
    parameter int TW_AW = 6
);
    logic                   in_valid;
    logic                   in_ready;
    logic                   advance;
    logic [2*LOG2N-1:0]     stage_mode;
    logic [LOG2N*TW_AW-1:0] tw_addr;
    logic                   out_valid;
    logic [LOG2N-1:0]       out_idx;
    logic                   frame_done;

    modport master (
        output in_valid,
        input  in_ready, advance, stage_mode, tw_addr,
        input  out_valid, out_idx, frame_done
    );

    modport slave (
        input  in_valid,
        output in_ready, advance, stage_mode, tw_addr,
        output out_valid, out_idx, frame_done
    );
endinterface

// File: rtl/fft_stage_ctrl.sv
// Per-stage mode and twiddle index derived from the shared
// sample index g and fill level.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int N     = 128,
    parameter int LOG2N = 7,
    parameter int TW_AW = 6,
    parameter int S     = 0
) (
    input  logic [LOG2N-1:0] g,
    input  logic [LOG2N:0]   fill,
    output logic [1:0]       mode,
    output logic [TW_AW-1:0] tw_addr
);
    localparam int L = stage_offset(S, N);
    localparam int D = N >> (S + 1);
    localparam logic [LOG2N-1:0] L_G    = LOG2N'(L);
    localparam logic [LOG2N:0]   L_F    = (LOG2N + 1)'(L);
    localparam logic [LOG2N-1:0] D_MASK = LOG2N'(D - 1);

    logic [LOG2N-1:0] j;
    logic             active;
    logic             bf;

    // Stage 0 sees data from the first sample, so it is never gated.
    if (S == 0) begin : g_first
        assign active = fill <= (LOG2N + 1)'(N);
    end else begin : g_later
        assign active = fill >= L_F;
    end

    assign j  = g - L_G;
    assign bf = j[LOG2N-1-S];

    always_comb begin
        mode    = MODE_IDLE;
        tw_addr = '0;
        if (active) begin
            mode = bf ? MODE_BFLY : MODE_LOAD;
            if (!bf) begin
                tw_addr = TW_AW'((j & D_MASK) << S);
            end
        end
    end
endmodule

// File: rtl/fft_stage_sequencer.sv
// Central scheduler for the radix-2 SDF FFT: sample counting,
// per-stage modes/twiddles, drain control and output tagging.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int N     = 128,
    parameter int LOG2N = 7,
    parameter int TW_AW = 6
) (
    input logic                  clk,
    input logic                  rst,
    fft_stage_sequencer_if.slave bus
);
    state_t                 state_q, state_d;
    logic [LOG2N-1:0]       g_q, g_d;
    logic [LOG2N:0]         fill_q, fill_d;
    logic [LOG2N-1:0]       drain_q, drain_d;
    logic                   accept, adv, last_drain, ov_d;
    logic [2*LOG2N-1:0]     mode_c, mode_q;
    logic [LOG2N*TW_AW-1:0] tw_c, tw_q;
    logic [LOG2N-1:0]       idx_q;
    logic                   ov_q, fd_q;

    for (genvar s = 0; s < LOG2N; s++) begin : g_stage
        fft_stage_ctrl #(
            .N(N), .LOG2N(LOG2N), .TW_AW(TW_AW), .S(s)
        ) u_ctrl (
            .g       (g_q),
            .fill    (fill_q),
            .mode    (mode_c[2*s +: 2]),
            .tw_addr (tw_c[s*TW_AW +: TW_AW])
        );
    end

    assign bus.in_ready = !rst && (state_q != ST_DRAIN);
    assign accept       = bus.in_valid && bus.in_ready;
    assign adv          = !rst && (accept || state_q == ST_DRAIN);
    assign ov_d         = adv && (fill_q >= (LOG2N + 1)'(N - 1));

    always_comb begin
        state_d    = state_q;
        g_d        = adv ? g_q + 1'b1 : g_q;
        fill_d     = fill_q;
        drain_d    = drain_q;
        last_drain = 1'b0;
        if (adv && fill_q != (LOG2N + 1)'(N)) begin
            fill_d = fill_q + 1'b1;
        end
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_RUN;
            end
            ST_RUN: begin
                // A gap only drains on a frame boundary; mid-frame it stalls.
                if (!bus.in_valid && g_q == '0 && fill_q != '0) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                drain_d = drain_q + 1'b1;
                if (drain_q == LOG2N'(N - 2)) begin
                    last_drain = 1'b1;
                    state_d    = ST_IDLE;
                    g_d        = '0;
                    fill_d     = '0;
                    drain_d    = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            fill_q  <= '0;
            drain_q <= '0;
            mode_q  <= '0;
            tw_q    <= '0;
            idx_q   <= '0;
            ov_q    <= 1'b0;
            fd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            fill_q  <= fill_d;
            drain_q <= drain_d;
            ov_q    <= ov_d;
            fd_q    <= last_drain;
            if (adv) begin
                mode_q <= mode_c;
                tw_q   <= tw_c;
                idx_q  <= g_q - LOG2N'(N - 1);
            end
        end
    end

    assign bus.advance    = adv;
    assign bus.stage_mode = mode_q;
    assign bus.tw_addr    = tw_q;
    assign bus.out_valid  = ov_q;
    assign bus.out_idx    = idx_q;
    assign bus.frame_done = fd_q;
endmodule
